// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the streaming ShiftRows stage.
`timescale 1ns/1ps
package aes_pkg;

  localparam int AES_NB    = 4;
  localparam int AES_COL_W = 32;

  typedef logic [7:0]                        aes_byte_t;
  typedef logic [AES_COL_W-1:0]              aes_col_t;
  typedef logic [1:0]                        aes_col_idx_t;
  typedef logic [AES_NB-1:0][AES_COL_W-1:0]  aes_state_t;

  typedef enum logic {
    SHIFT_FWD = 1'b0,
    SHIFT_INV = 1'b1
  } aes_shift_dir_t;

  // Row 0 is the most significant byte of a column.
  function automatic aes_byte_t get_byte(input aes_col_t col, input aes_col_idx_t row);
    aes_byte_t b;
    case (row)
      2'd0:    b = col[31:24];
      2'd1:    b = col[23:16];
      2'd2:    b = col[15:8];
      default: b = col[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/aes_state_bank.sv
// One buffered AES state: column-write register file, full/direction flags
// and the row-shift read mux.
`timescale 1ns/1ps
module aes_state_bank
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_col,
  input  logic [31:0] wr_data,
  input  logic        wr_inv,
  input  logic        rd_done,
  input  logic [1:0]  rd_col,
  output logic        full,
  output logic [31:0] rd_data
);

  aes_col_t       col_reg [AES_NB];
  aes_shift_dir_t dir_reg;
  logic           full_reg;
  logic           wr_ok;

  // A full bank is never overwritten, whatever the caller requests.
  assign wr_ok = wr_en && !full_reg;
  assign full  = full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < AES_NB; c++) col_reg[c] <= '0;
    end else if (wr_ok) begin
      col_reg[wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      dir_reg  <= SHIFT_FWD;
    end else begin
      if (wr_ok && wr_col == 2'd3) full_reg <= 1'b1;
      else if (rd_done)            full_reg <= 1'b0;
      if (wr_ok && wr_col == 2'd0) dir_reg <= aes_shift_dir_t'(wr_inv);
    end
  end

  generate
    for (genvar gi = 0; gi < AES_NB; gi++) begin : g_row
      aes_col_idx_t fwd_idx;
      aes_col_idx_t inv_idx;
      aes_col_idx_t sel_idx;
      assign fwd_idx = rd_col + aes_col_idx_t'(gi);
      assign inv_idx = rd_col - aes_col_idx_t'(gi);
      assign sel_idx = (dir_reg == SHIFT_INV) ? inv_idx : fwd_idx;
      assign rd_data[(AES_COL_W-1)-8*gi -: 8] = get_byte(col_reg[sel_idx], aes_col_idx_t'(gi));
    end
  endgenerate

endmodule

// File: rtl/aes_shift_rows_stream.sv
// Streaming AES ShiftRows with ping-pong state banks.
// Define AES_SHIFT_ROWS_INV_EN to add the per-block inv (InvShiftRows) port.
`timescale 1ns/1ps
module aes_shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NUM_BANKS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] din,
`ifdef AES_SHIFT_ROWS_INV_EN
  input  logic        inv,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        out_last
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int NS = 1 << BW;

  logic [BW-1:0] wr_bank_reg;
  logic [BW-1:0] rd_bank_reg;
  aes_col_idx_t  wr_col_reg;
  aes_col_idx_t  rd_col_reg;
  logic [NS-1:0] full_vec;
  aes_col_t      rd_data_vec [NS];
  logic          wr_fire;
  logic          rd_fire;
  logic          inv_in;

`ifdef AES_SHIFT_ROWS_INV_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  assign in_ready  = !full_vec[wr_bank_reg];
  assign out_valid = full_vec[rd_bank_reg];
  assign out_last  = out_valid && (rd_col_reg == 2'd3);
  assign dout      = out_valid ? rd_data_vec[rd_bank_reg] : '0;
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_bank
      if (gi < NUM_BANKS) begin : g_real
        aes_state_bank u_bank (
          .clk     (clk),
          .rst_n   (rst_n),
          .wr_en   (wr_fire && wr_bank_reg == BW'(gi)),
          .wr_col  (wr_col_reg),
          .wr_data (din),
          .wr_inv  (inv_in),
          .rd_done (rd_fire && rd_col_reg == 2'd3 && rd_bank_reg == BW'(gi)),
          .rd_col  (rd_col_reg),
          .full    (full_vec[gi]),
          .rd_data (rd_data_vec[gi])
        );
      end else begin : g_pad
        // Unused slots of the power-of-two select space read as empty.
        assign full_vec[gi]    = 1'b0;
        assign rd_data_vec[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_reg <= '0;
      wr_col_reg  <= '0;
      rd_bank_reg <= '0;
      rd_col_reg  <= '0;
    end else begin
      if (wr_fire) begin
        wr_col_reg <= wr_col_reg + 2'd1;
        if (wr_col_reg == 2'd3) wr_bank_reg <= next_bank(wr_bank_reg);
      end
      if (rd_fire) begin
        rd_col_reg <= rd_col_reg + 2'd1;
        if (rd_col_reg == 2'd3) rd_bank_reg <= next_bank(rd_bank_reg);
      end
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_stream.sv
// Scoreboard bench for aes_shift_rows_stream using hand-computed ShiftRows vectors.
`timescale 1ns/1ps
module tb_aes_shift_rows_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] din = '0;
  logic        inv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dout;
  logic        out_last;

  always #5 clk = ~clk;

  aes_shift_rows_stream #(.NUM_BANKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
`ifdef AES_SHIFT_ROWS_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_popped = 0;
  int   n_acc    = 0;

  logic [31:0] fips_in  [4] = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
  logic [31:0] fips_out [4] = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
  logic [31:0] b_out    [4] = '{32'hd4b411e5, 32'he0419830, 32'hb8275dae, 32'h1ebf52f1};
  logic [31:0] s_in     [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] s_out    [4] = '{32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_block(input logic [31:0] o [4]);
    for (int i = 0; i < 4; i++) exp_q.push_back('{data: o[i], last: (i == 3)});
  endtask

  task automatic send(input logic [31:0] d, input logic iv, output int stalls);
    in_valid = 1'b1;
    din      = d;
    inv      = iv;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 300) begin
        n_checks++;
        n_err++;
        $display("FAIL send_timeout: got stalled required accept");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [31:0] d [4], input logic iv, output int stalls);
    int s;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      send(d[i], iv, s);
      stalls += s;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on each output handshake, check stability while stalled.
  logic        hold_pending = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (in_valid && in_ready) n_acc++;
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_dout", dout, hold_d);
        check("hold_last", out_last, hold_l);
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", dout, 0);
        end else begin
          e = exp_q.pop_front();
          n_popped++;
          check("dout", dout, e.data);
          check("out_last", out_last, e.last);
        end
      end else if (out_valid) begin
        hold_pending = 1'b1;
        hold_d = dout;
        hold_l = out_last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int st, st2, acc0, pop0, n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_dout", dout, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: FIPS-197 round 1, latency
    out_ready = 1'b1;
    push_block(fips_out);
    for (int i = 0; i < 3; i++) send(fips_in[i], 1'b0, st);
    check("lat_before_col3", out_valid, 0);
    send(fips_in[3], 1'b0, st);
    check("lat_after_col3", out_valid, 1);
    in_valid = 1'b0;
    wait_drain("c1_drain");

    // 2: back-to-back blocks, continuous output
    push_block(s_out);
    push_block(b_out);
    fork
      begin
        send_block(s_in, 1'b0, st);
        send_block(fips_out, 1'b0, st2);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 8; k++) begin
          check("c2_cont_valid", out_valid, 1);
          @(negedge clk);
        end
      end
    join
    check("c2_no_stall", st + st2, 0);
    wait_drain("c2_drain");

    // 3: backpressure, then release
    out_ready = 1'b0;
    acc0 = n_acc;
    push_block(s_out);
    push_block(fips_out);
    push_block(b_out);
    fork
      begin
        send_block(s_in, 1'b0, st);
        send_block(fips_in, 1'b0, st);
        send_block(fips_out, 1'b0, st);
        in_valid = 1'b0;
      end
      begin
        repeat (14) @(negedge clk);
        check("c3_in_ready_low", in_ready, 0);
        check("c3_accepted", n_acc - acc0, 8);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_last) && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("c3_free_same_cycle", in_ready, 0);
        @(negedge clk);
        check("c3_free_next_cycle", in_ready, 1);
      end
    join
    wait_drain("c3_drain");

    // 4: reset mid-block with a full, undrained bank
    out_ready = 1'b0;
    send_block(s_in, 1'b0, st);
    send(fips_in[0], 1'b0, st);
    send(fips_in[1], 1'b0, st);
    in_valid = 1'b0;
    check("c4_pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("c4_rst_in_ready", in_ready, 1);
    check("c4_rst_out_valid", out_valid, 0);
    check("c4_rst_out_last", out_last, 0);
    check("c4_rst_dout", dout, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_block(fips_out);
    send_block(fips_in, 1'b0, st);
    in_valid = 1'b0;
    wait_drain("c4_drain");

    // 5: out_ready toggling
    pop0 = n_popped;
    push_block(s_out);
    push_block(b_out);
    push_block(fips_out);
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
      begin
        send_block(s_in, 1'b0, st);
        send_block(fips_out, 1'b0, st);
        send_block(fips_in, 1'b0, st);
        in_valid = 1'b0;
      end
    join
    out_ready = 1'b1;
    wait_drain("c5_drain");
    check("c5_count", n_popped - pop0, 12);

`ifdef AES_SHIFT_ROWS_INV_EN
    // 6: InvShiftRows block followed by a forward block
    push_block(fips_in);
    push_block(s_out);
    send_block(fips_out, 1'b1, st);
    send_block(s_in, 1'b0, st);
    in_valid = 1'b0;
    wait_drain("c6_drain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
